sum_block_accumulator: RTL and testbench
========================================

SUM_BLOCK_ACCUMULATOR -- requirements
Module: sum_block_accumulator

Interface
REQ-001 Parameter: width, default 8, bit width of each incoming sum beat.
REQ-002 Parameter: count, default 4, number of incoming beats folded into one result; legal range 2..256.
REQ-003 Derived result width: rwidth = width + ceil(log2(count)), which is 10 for the defaults.
REQ-004 Port: clk  input  1  the single clock; all state updates on the rising edge.
REQ-005 Port: rst  input  1  asynchronous, active-low reset; state clears immediately while rst=0.
REQ-006 Port: up_valid  input  1  upstream beat present; driven by the sum stream of the adder/double-buffer stage.
REQ-007 Port: up_ready  output  1  block accepts the beat this cycle.
REQ-008 Port: up_data  input  width  unsigned sum beat.
REQ-009 Port: down_valid  output  1  registered result present.
REQ-010 Port: down_ready  input  1  downstream accepts the result this cycle.
REQ-011 Port: down_data  output  rwidth  unsigned sum of count consecutive accepted beats.

Function
REQ-012 An upstream transfer SHALL occur in a cycle iff up_valid=1 and up_ready=1 at the rising edge; a downstream transfer likewise uses down_valid and down_ready.
REQ-013 A beat counter cnt SHALL range 0..count-1, advance by 1 per upstream transfer, and wrap to 0 after the transfer taken at cnt=count-1 (the "last beat").
REQ-014 An accumulator acc of rwidth bits SHALL hold the zero-extended sum of the beats accepted since the last wrap; at cnt=0 an accepted beat loads acc with up_data rather than adding to it.
REQ-015 For a non-last beat, acc and cnt SHALL update and down_valid/down_data SHALL be unchanged.
REQ-016 For the last beat, down_data SHALL load acc+up_data (full rwidth, no overflow possible), down_valid SHALL become 1, and acc SHALL clear to 0.
REQ-017 Latency: down_valid SHALL rise on the clock edge that accepts the last beat, i.e. the result is visible in the following cycle.
REQ-018 up_ready SHALL be 1 when cnt≠count-1; when cnt=count-1 it SHALL equal (down_valid=0) OR (down_ready=1). This is a combinational path from down_ready, and non-last beats are never stalled by a held result.
REQ-019 up_ready SHALL NOT depend on up_valid.
REQ-020 While down_valid=1 and down_ready=0, down_data and down_valid SHALL hold stable.
REQ-021 A downstream transfer with no simultaneous last-beat acceptance SHALL clear down_valid.
REQ-022 A simultaneous downstream transfer and last-beat acceptance SHALL keep down_valid=1 and load the new result, sustaining one result per count cycles with no bubble.
REQ-023 When up_valid=0 (a bubble), cnt and acc SHALL hold; partial blocks persist indefinitely.
REQ-024 up_data SHALL be treated as unsigned; there is no saturation or wrap, since rwidth covers count×(2^width−1).

Reset
REQ-025 While rst=0: cnt=0, acc=0, down_valid=0, down_data=0; up_ready therefore reads 1.
REQ-026 Reset asserted mid-block SHALL discard the partial accumulation and any unaccepted result; the first block after release SHALL start at cnt=0.
REQ-027 Deassertion SHALL be clean on the next rising edge; no transfer is counted in a cycle where rst=0 at the edge.

Verification (width=8, count=4)
REQ-028 Beats 1,2,3,4 back-to-back with down_ready=1 -> down_valid=1 for one cycle with down_data=10, one cycle after beat 4.
REQ-029 Four beats of 255 -> down_data=1020 (0x3FC), with no truncation.
REQ-030 down_ready=0 while 8 beats of value 1 are offered continuously -> first result 4 held stable; beats 5-7 are accepted; up_ready=0 at beat 8 until down_ready=1, then beat 8 is accepted in that same cycle and the second result 4 follows.
REQ-031 down_ready=1 with 12 continuous beats 1..12 -> results 10, 26, 42 each valid exactly one cycle, and up_ready stays 1 throughout.
REQ-032 Beats 7,7 then rst pulsed low mid-cycle, then 5,5,5,5 -> down_valid drops immediately; the single result is 20, with no contribution from the 7s.
REQ-033 Beats 1,2,3,4 with up_valid toggling 1,0 every cycle and random down_ready -> results unchanged (10), and no beat is lost or duplicated.

Source files
------------

// File: rtl/sum_block_accumulator.sv
// Folds every `count` consecutive accepted upstream beats into one unsigned result.
// The result is held in a one-deep output register with a valid/ready handshake.
module sum_block_accumulator #(
    parameter int width = 8,
    parameter int count = 4,
    localparam int cwidth = $clog2(count),
    localparam int rwidth = width + cwidth
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [width-1:0]  up_data,
    output logic              down_valid,
    input  logic              down_ready,
    output logic [rwidth-1:0] down_data
);

    generate
        if (count < 2 || count > 256) begin : g_bad_count
            $error("sum_block_accumulator: count must lie in 2..256");
        end
    endgenerate

    localparam logic [cwidth-1:0] LAST_CNT = cwidth'(count - 1);

    logic [cwidth-1:0] cnt_q,        cnt_d;
    logic [rwidth-1:0] acc_q,        acc_d;
    logic              down_valid_q, down_valid_d;
    logic [rwidth-1:0] down_data_q,  down_data_d;

    logic              last_beat;
    logic              up_fire;
    logic              down_fire;
    logic [rwidth-1:0] beat_ext;
    logic [rwidth-1:0] sum;

    assign last_beat = (cnt_q == LAST_CNT);

    // Only the closing beat can be blocked, and only by a result that is not leaving.
    assign up_ready  = !last_beat || !down_valid_q || down_ready;
    assign up_fire   = up_valid && up_ready;
    assign down_fire = down_valid_q && down_ready;

    assign beat_ext  = {{cwidth{1'b0}}, up_data};
    assign sum       = ((cnt_q == '0) ? '0 : acc_q) + beat_ext;

    always_comb begin
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        down_valid_d = down_valid_q;
        down_data_d  = down_data_q;

        if (down_fire) begin
            down_valid_d = 1'b0;
        end

        if (up_fire) begin
            if (last_beat) begin
                cnt_d        = '0;
                acc_d        = '0;
                down_data_d  = sum;
                down_valid_d = 1'b1;
            end else begin
                cnt_d = cnt_q + cwidth'(1);
                acc_d = sum;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q        <= '0;
            acc_q        <= '0;
            down_valid_q <= 1'b0;
            down_data_q  <= '0;
        end else begin
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            down_valid_q <= down_valid_d;
            down_data_q  <= down_data_d;
        end
    end

    assign down_valid = down_valid_q;
    assign down_data  = down_data_q;

endmodule

// File: tb/tb_sum_block_accumulator.sv
// Randomised and directed checks of sum_block_accumulator against a block-sum model.
module tb_sum_block_accumulator;

    localparam int W  = 8;
    localparam int C  = 4;
    localparam int RW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          up_valid = 1'b0;
    logic          down_ready = 1'b0;
    logic [W-1:0]  up_data = '0;
    logic          up_ready;
    logic          down_valid;
    logic [RW-1:0] down_data;

    sum_block_accumulator #(.width(W), .count(C)) dut (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .up_data    (up_data),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .down_data  (down_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: beats accepted in the open block, and at most one finished block sum awaiting pickup.
    int m_beats = 0;
    int m_sum   = 0;
    bit m_pend  = 0;
    int m_res   = 0;
    int m_out[$];
    int d_out[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        bit exp_ur;
        bit up_fire;
        if (!rst) begin
            chk("rst_down_valid", down_valid, 0);
            chk("rst_down_data", down_data, 0);
            chk("rst_up_ready", up_ready, 1);
            m_beats = 0;
            m_sum   = 0;
            m_pend  = 0;
        end else begin
            exp_ur = (m_beats != C - 1) || !m_pend || down_ready;
            chk("up_ready", up_ready, exp_ur);
            chk("down_valid", down_valid, m_pend);
            if (m_pend) chk("down_data", down_data, m_res);
            if (down_valid && down_ready) d_out.push_back(int'(down_data));
            up_fire = up_valid && exp_ur;
            if (m_pend && down_ready) begin
                m_out.push_back(m_res);
                m_pend = 0;
            end
            if (up_fire) begin
                m_sum += int'(up_data);
                m_beats++;
                if (m_beats == C) begin
                    m_pend  = 1;
                    m_res   = m_sum;
                    m_sum   = 0;
                    m_beats = 0;
                end
            end
        end
    end

    task automatic drive(input bit v, input int d, input bit dr);
        up_valid   = v;
        up_data    = W'(d);
        down_ready = dr;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        up_valid = 0;
        rst = 0;
        #1;
        chk("rst_async_drop", down_valid, 0);
        chk("rst_async_ready", up_ready, 1);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1;
        @(posedge clk);
        #1;
        d_out.delete();
        m_out.delete();
    endtask

    task automatic pin(input string name, input int exp_q[$]);
        chk({name, "_count_dut"}, d_out.size(), exp_q.size());
        chk({name, "_count_model"}, m_out.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < d_out.size()) chk({name, "_dut"}, d_out[i], exp_q[i]);
            if (i < m_out.size()) chk({name, "_model"}, m_out[i], exp_q[i]);
        end
    endtask

    // Offers each beat until accepted; gap_mode 0=none 1=toggle 2=random, dr_mode 0=low 1=high 2=random.
    task automatic run_beats(input int beats[$], input int gap_mode, input int dr_mode, input int max_cycles);
        int idx = 0;
        int cyc = 0;
        bit v;
        bit took;
        while (idx < beats.size() && cyc < max_cycles) begin
            v = (gap_mode == 0) ? 1'b1 : (gap_mode == 1) ? (cyc % 2 == 0) : 1'($urandom % 2);
            up_valid   = v;
            up_data    = W'(beats[idx]);
            down_ready = (dr_mode == 0) ? 1'b0 : (dr_mode == 1) ? 1'b1 : 1'($urandom % 2);
            @(negedge clk);
            took = v && up_ready;
            @(posedge clk);
            #1;
            if (took) idx++;
            cyc++;
        end
        chk("beats_accepted", idx, beats.size());
        up_valid = 0;
    endtask

    initial begin
        #1 rst = 0;
        @(posedge clk);
        #3 rst = 1;
        @(posedge clk);
        #1;
        d_out.delete();
        m_out.delete();

        run_beats('{1, 2, 3, 4}, 0, 1, 20);
        drain(3);
        pin("seq_1234", '{10});

        do_reset();
        run_beats('{255, 255, 255, 255}, 0, 1, 20);
        drain(3);
        pin("max_beats", '{1020});

        do_reset();
        for (int i = 0; i < 7; i++) drive(1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            up_valid = 1; up_data = 1; down_ready = 0;
            #1;
            chk("stall_up_ready", up_ready, 0);
            chk("stall_hold_data", down_data, 4);
            @(posedge clk);
            #1;
        end
        up_valid = 1; up_data = 1; down_ready = 1;
        #1;
        chk("release_up_ready", up_ready, 1);
        @(posedge clk);
        #1;
        drain(3);
        pin("held_result", '{4, 4});

        do_reset();
        run_beats('{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12}, 0, 1, 20);
        drain(3);
        pin("stream_12", '{10, 26, 42});

        do_reset();
        run_beats('{9, 9, 9, 9}, 0, 0, 20);
        run_beats('{7, 7}, 0, 0, 20);
        chk("pre_rst_valid", down_valid, 1);
        do_reset();
        run_beats('{5, 5, 5, 5}, 0, 1, 20);
        drain(3);
        pin("reset_mid", '{20});

        do_reset();
        run_beats('{1, 2, 3, 4}, 1, 2, 100);
        drain(3);
        pin("toggle_valid", '{10});

        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom % 4 != 0), int'($urandom_range(0, 255)), 1'($urandom % 3 != 0));
        end
        drain(4);
        chk("rand_count", d_out.size(), m_out.size());
        chk("rand_nonempty", d_out.size() > 10, 1);
        for (int i = 0; i < d_out.size() && i < m_out.size(); i++) chk("rand_result", d_out[i], m_out[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
